baudrate_generator_prog: RTL and testbench
==========================================

Name: baudrate_generator_prog

Overview:
- Runtime-programmable baud-rate generator for the UART TX/RX path.
- Produces a one-cycle oversampling tick (o_tick) and a one-cycle bit-rate tick (o_bit_tick, every OVERSAMPLE ticks).
- Divisor is loadable at run time through a load/ack handshake, applied glitch-free at a tick boundary.
- Optional fractional divisor gives accurate rates from clocks that do not divide evenly.

Parameters:
- NB_DIV, 16, width of integer divisor.
- NB_FRAC, 4, width of fractional divisor (units of 1/2^NB_FRAC cycle).
- OVERSAMPLE, 16, o_tick pulses per o_bit_tick (>=2).
- DEFAULT_DIV, 163, integer divisor after reset.
- DEFAULT_FRAC, 0, fractional divisor after reset.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  count enable; low freezes all state.
- i_div  in  NB_DIV  requested integer divisor.
- i_frac  in  NB_FRAC  requested fractional divisor.
- i_load  in  1  load request; i_div/i_frac sampled in the same cycle.
- o_load_ack  out  1  one-cycle pulse when a loaded divisor takes effect.
- o_pending  out  1  high while a loaded divisor waits to be applied.
- o_tick  out  1  oversampling tick, one-cycle pulse.
- o_bit_tick  out  1  bit-rate tick, one-cycle pulse, coincident with an o_tick.

Behaviour:
- Reset (async, immediate, any state):
  - count=0, sub=0, acc=0.
  - div_reg=DEFAULT_DIV, frac_reg=DEFAULT_FRAC, shadow cleared.
  - All outputs 0.
- Effective period P:
  - P = div_reg, plus 1 on a fractional carry cycle.
  - div_reg 0 is treated as 1.
  - With div_reg=1 and enable high, o_tick is high every cycle.
- Counter:
  - While i_enable=1, count runs 0..P-1.
  - o_tick is registered, high for one cycle each time count wraps.
  - The first o_tick after reset release (enable held high) is on the P-th rising edge.
- Fractional accumulator:
  - On each o_tick, acc <= acc + frac_reg (NB_FRAC bits).
  - A carry out makes the next period div_reg+1.
  - Average period = div_reg + frac_reg/2^NB_FRAC.
- Sub-counter:
  - sub increments on each o_tick and wraps at OVERSAMPLE-1 -> 0.
  - o_bit_tick is high on the same cycle as the o_tick that wraps sub.
- Enable:
  - i_enable=0 holds count, acc, sub; outputs 0.
  - Re-enabling resumes from the held count with no extra tick.
- Load handshake:
  - i_load=1 captures i_div/i_frac into shadow; o_pending=1 next cycle.
  - Shadow is applied on the cycle o_tick is high (or on the next cycle if i_enable=0).
  - On apply: div_reg/frac_reg <= shadow; count, acc, sub cleared.
  - o_pending falls and o_load_ack pulses on the cycle after apply.
  - Period under new divisor starts counting from the apply cycle.
- Load boundary cases:
  - i_load while pending: shadow overwritten (last wins); only one ack.
  - i_load on the same cycle as an o_tick: value captured, applied at the following tick, not the current one.
  - Reset while pending: shadow discarded, no ack.

Optional Feature:
- Macro: BRG_FRAC_EN
- Defined: fractional accumulator present; i_frac and DEFAULT_FRAC honoured as above.
- Undefined:
  - i_frac ignored; no accumulator logic.
  - Period is exactly max(div_reg,1).
  - Port list unchanged.

Test Plan:
- Reset high 20 ns, then enable=1, DIV=163, 10 ns clock -> o_tick every 1630 ns; o_bit_tick every 26080 ns; all outputs 0 during reset.
- Load DIV=10 mid-period -> o_pending high until the next tick; o_load_ack pulses once the cycle after; subsequent ticks every 10 cycles; sub restarts at 0.
- BRG_FRAC_EN, DIV=10, FRAC=8 (NB_FRAC=4) -> periods alternate 10,11; 32 ticks span 336 cycles.
- Two loads (DIV=20 then DIV=5) before the next tick -> single ack; period 5 applied.
- Enable low for 50 cycles mid-count, then high -> no ticks while low; next tick after the remaining count, none extra.
- DIV=1 -> o_tick high every cycle, o_bit_tick every OVERSAMPLE cycles; DIV=0 -> identical behaviour; async reset mid-run -> outputs 0 immediately.

Source files
------------

// File: rtl/baudrate_generator_prog.sv
// Programmable baud-rate generator: oversampling tick plus bit-rate tick, divisor loaded via load/ack.
// Define BRG_FRAC_EN to build in the fractional-divisor accumulator.
module baudrate_generator_prog #(
  parameter int NB_DIV       = 16,
  parameter int NB_FRAC      = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_DIV  = 163,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DIV-1:0]  i_div,
  input  logic [NB_FRAC-1:0] i_frac,
  input  logic               i_load,
  output logic               o_load_ack,
  output logic               o_pending,
  output logic               o_tick,
  output logic               o_bit_tick
);

  localparam int NB_CNT = NB_DIV + 1;
  localparam int NB_SUB = $clog2(OVERSAMPLE);
  localparam logic [NB_SUB-1:0] SUB_LAST = NB_SUB'(OVERSAMPLE - 1);

  logic [NB_CNT-1:0] count_q, count_d, base_count, period;
  logic [NB_SUB-1:0] sub_q, sub_d, base_sub;
  logic [NB_DIV-1:0] div_q, shadow_div_q, shadow_div_d, base_div;
  logic              pending_q, pending_d, ack_q;
  logic              tick_q, tick_d, bit_q, bit_d;
  logic              apply, wrap, step_wrap, carry;

  // Apply at the end of a tick cycle; a load in that same cycle defers it to the next tick.
  assign apply     = pending_q & ~i_load & (tick_q | ~i_enable);
  assign step_wrap = i_enable & wrap;

`ifdef BRG_FRAC_EN
  logic [NB_FRAC-1:0] frac_q, shadow_frac_q, shadow_frac_d, base_frac;
  logic [NB_FRAC-1:0] acc_q, acc_d, base_acc;
  logic               carry_q, carry_d;

  assign carry = apply ? 1'b0 : carry_q;

  always_comb begin
    base_frac = apply ? shadow_frac_q : frac_q;
    base_acc  = apply ? '0 : acc_q;
    acc_d     = base_acc;
    carry_d   = carry;
    if (step_wrap) begin
      {carry_d, acc_d} = {1'b0, base_acc} + {1'b0, base_frac};
    end
    shadow_frac_d = i_load ? i_frac : shadow_frac_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      frac_q        <= NB_FRAC'(DEFAULT_FRAC);
      shadow_frac_q <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
    end else begin
      frac_q        <= base_frac;
      shadow_frac_q <= shadow_frac_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^{i_frac, NB_FRAC'(DEFAULT_FRAC)};
  assign carry       = 1'b0;
`endif

  always_comb begin
    base_div   = apply ? shadow_div_q : div_q;
    base_count = apply ? '0 : count_q;
    base_sub   = apply ? '0 : sub_q;
    period     = ((base_div == '0) ? NB_CNT'(1) : {1'b0, base_div}) + NB_CNT'(carry);
    wrap       = (base_count >= period - NB_CNT'(1));

    count_d = base_count;
    sub_d   = base_sub;
    tick_d  = 1'b0;
    bit_d   = 1'b0;
    if (i_enable) begin
      if (wrap) begin
        count_d = '0;
        tick_d  = 1'b1;
        bit_d   = (base_sub == SUB_LAST);
        sub_d   = bit_d ? '0 : base_sub + 1'b1;
      end else begin
        count_d = base_count + 1'b1;
      end
    end

    pending_d    = i_load | (pending_q & ~apply);
    shadow_div_d = i_load ? i_div : shadow_div_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q      <= '0;
      sub_q        <= '0;
      div_q        <= NB_DIV'(DEFAULT_DIV);
      shadow_div_q <= '0;
      pending_q    <= 1'b0;
      ack_q        <= 1'b0;
      tick_q       <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      sub_q        <= sub_d;
      div_q        <= base_div;
      shadow_div_q <= shadow_div_d;
      pending_q    <= pending_d;
      ack_q        <= apply;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
    end
  end

  assign o_load_ack = ack_q;
  assign o_pending  = pending_q;
  assign o_tick     = tick_q;
  assign o_bit_tick = bit_q;

endmodule

// File: tb/tb_baudrate_generator_prog.sv
// Bench for baudrate_generator_prog: tick times predicted in closed form from divisor and fraction.
// Fractional scenarios are included only when BRG_FRAC_EN is defined.
module tb_baudrate_generator_prog;

  localparam int OS = 16;
  localparam int FSCALE = 16;
`ifdef BRG_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] dv = '0;
  logic [3:0]  fr = '0;
  logic        o_load_ack, o_pending, o_tick, o_bit_tick;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  int m_div, m_frac, sh_div, sh_frac, e, n;
  bit m_pend, m_tick, m_bit, m_ack;

  baudrate_generator_prog dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_div(dv), .i_frac(fr), .i_load(ld),
    .o_load_ack(o_load_ack), .o_pending(o_pending), .o_tick(o_tick), .o_bit_tick(o_bit_tick)
  );

  always #5 clk = ~clk;

  // Enabled cycle (counted from the period origin) on which the k-th tick appears.
  function automatic longint t_of(int k);
    int p;
    p = (m_div == 0) ? 1 : m_div;
    return longint'(k) * p + (longint'(k - 1) * m_frac) / FSCALE;
  endfunction

  task automatic model_reset();
    m_div = 163; m_frac = 0; sh_div = 0; sh_frac = 0;
    e = 0; n = 0; cyc = 0;
    m_pend = 0; m_tick = 0; m_bit = 0; m_ack = 0;
  endtask

  task automatic step(input bit s_en, input bit s_ld, input int s_div, input int s_frac);
    bit app, nt, nb;
    en = s_en; ld = s_ld; dv = s_div[15:0]; fr = s_frac[3:0];
    @(posedge clk);
    cyc++;
    app = m_pend && !s_ld && (m_tick || !s_en);
    nt = 0; nb = 0;
    if (app) begin
      m_div = sh_div; m_frac = FRAC_EN ? sh_frac : 0; e = 0; n = 0;
    end
    if (s_en) begin
      e++;
      if (longint'(e) == t_of(n + 1)) begin
        n++; nt = 1; nb = (n % OS == 0);
      end
    end
    m_ack = app;
    if (s_ld) begin
      sh_div = s_div; sh_frac = s_frac; m_pend = 1;
    end else if (app) m_pend = 0;
    m_tick = nt; m_bit = nb;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    #12;
    checks++;
    if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", {o_tick, o_bit_tick, o_pending, o_load_ack});
    end
    #8;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_default_rate();
    int ticks = 0, bits = 0, first_tick = -1, first_bit = -1;
    for (int i = 0; i < 2620; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL default_rate cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_tick) begin ticks++; if (first_tick < 0) first_tick = cyc; end
      if (o_bit_tick) begin bits++; if (first_bit < 0) first_bit = cyc; end
    end
    checks++;
    if (first_tick != 163) begin failures++; $display("FAIL first_tick got=%0d exp=163", first_tick); end
    checks++;
    if (first_bit != 2608) begin failures++; $display("FAIL first_bit_tick got=%0d exp=2608", first_bit); end
    checks++;
    if (ticks != 16 || bits != 1) begin failures++; $display("FAIL default_counts got=%0d/%0d exp=16/1", ticks, bits); end
  endtask

  task automatic test_load_mid();
    int acks = 0, last = -1, gap = 0;
    step(1, 1, 10, 0);
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL load_mid cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_load_ack) acks++;
      if (o_tick) begin if (last >= 0) gap = cyc - last; last = cyc; end
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL load_mid_acks got=%0d exp=1", acks); end
    checks++;
    if (gap != 10) begin failures++; $display("FAIL load_mid_period got=%0d exp=10", gap); end
  endtask

  task automatic test_load_on_tick();
    bit found = 0;
    int acks = 0, t_load = 0, next_tick = -1, last = -1, gap = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1, 0, 0, 0);
      found = o_tick;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL load_on_tick_sync got=0 exp=1"); end
    t_load = cyc;
    step(1, 1, 7, 0);
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL load_on_tick cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_load_ack) acks++;
      if (o_tick) begin
        if (next_tick < 0) next_tick = cyc;
        if (last >= 0) gap = cyc - last;
        last = cyc;
      end
    end
    checks++;
    if (next_tick - t_load != 10) begin failures++; $display("FAIL load_on_tick_old_period got=%0d exp=10", next_tick - t_load); end
    checks++;
    if (acks != 1 || gap != 7) begin failures++; $display("FAIL load_on_tick_new got=acks%0d/gap%0d exp=acks1/gap7", acks, gap); end
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    int acks = 0, last = -1, gap = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0);
      found = o_tick;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL b2b_sync got=0 exp=1"); end
    step(1, 1, 20, 0);
    step(1, 0, 0, 0);
    step(1, 1, 5, 0);
    for (int i = 0; i < 50; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_load_ack) acks++;
      if (o_tick) begin if (last >= 0) gap = cyc - last; last = cyc; end
    end
    checks++;
    if (acks != 1 || gap != 5) begin failures++; $display("FAIL b2b_result got=acks%0d/gap%0d exp=acks1/gap5", acks, gap); end
  endtask

  task automatic test_enable_gap();
    bit found = 0;
    int gap_ticks = 0, wait_cyc = 0;
    step(1, 1, 30, 0);
    for (int i = 0; i < 80; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, 0);
      found = o_tick;
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL enable_gap cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_tick) gap_ticks++;
    end
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1, 0, 0, 0);
      wait_cyc++;
      found = o_tick;
    end
    checks++;
    if (gap_ticks != 0 || wait_cyc != 20) begin
      failures++; $display("FAIL enable_resume got=ticks%0d/wait%0d exp=ticks0/wait20", gap_ticks, wait_cyc);
    end
  endtask

  task automatic test_div_min();
    int ticks;
    for (int d = 1; d >= 0; d--) begin
      ticks = 0;
      step(1, 1, d, 0);
      for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
        step(1, 0, 0, 0);
        checks++;
        if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
          failures++; $display("FAIL div_min d=%0d cyc=%0d got=%b exp=%b", d, cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
        end
        if (o_tick) ticks++;
      end
      checks++;
      if (ticks != 40) begin failures++; $display("FAIL div_min_ticks d=%0d got=%0d exp=40", d, ticks); end
    end
  endtask

`ifdef BRG_FRAC_EN
  task automatic test_frac();
    bit found = 0;
    int t0, ticks = 0;
    step(1, 1, 10, 8);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 0, 0, 0);
      found = o_tick;
    end
    t0 = cyc;
    for (int i = 0; i < 400 && ticks < 32; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL frac cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_tick) ticks++;
    end
    checks++;
    if (ticks != 32 || cyc - t0 != 336) begin failures++; $display("FAIL frac_span got=%0d exp=336", cyc - t0); end
  endtask
`endif

  task automatic test_random();
    bit r_en, r_ld;
    for (int i = 0; i < 3000; i++) begin
      r_en = ($urandom % 8) != 0;
      r_ld = ($urandom % 40) == 0;
      step(r_en, r_ld, int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
    end
  endtask

  task automatic test_async_reset();
    int acks = 0, first_tick = -1;
    step(1, 0, 0, 0);
    step(1, 1, 9, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== 4'b0000) begin
      failures++; $display("FAIL async_reset got=%b exp=0000", {o_tick, o_bit_tick, o_pending, o_load_ack});
    end
    #8 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if ({o_tick, o_bit_tick, o_pending, o_load_ack} !== {m_tick, m_bit, m_pend, m_ack}) begin
        failures++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, {o_tick, o_bit_tick, o_pending, o_load_ack}, {m_tick, m_bit, m_pend, m_ack});
      end
      if (o_load_ack) acks++;
      if (o_tick && first_tick < 0) first_tick = cyc;
    end
    checks++;
    if (acks != 0 || first_tick != 163) begin
      failures++; $display("FAIL post_reset_result got=acks%0d/first%0d exp=acks0/first163", acks, first_tick);
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_load_mid();
    test_load_on_tick();
    test_back_to_back();
    test_enable_gap();
    test_div_min();
`ifdef BRG_FRAC_EN
    test_frac();
`endif
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
